// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the fetch stage, hazard unit and IF/ID register.
//   DW             : data/address width
//   RESET_VEC_ADDR : memory location holding the boot PC
//   NOP_INSTR      : bubble encoding when no valid fetch is presented
//   INT_VEC_ADDR   : memory location holding the interrupt handler PC
//   fetch_state_e  : fetch FSM encoding (S_INTV only with FETCH_INTR_EN)
package cpu_defs;
  localparam int            DW             = 8;
  localparam logic [DW-1:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [DW-1:0] NOP_INSTR      = 8'h00;
  localparam logic [DW-1:0] INT_VEC_ADDR   = 8'h01;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
`ifdef FETCH_INTR_EN
    , S_INTV = 2'd3
`endif
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/execute/decode controls in, instruction memory
// address/data, and the IF/ID register feed out.
//   master : the fetch stage
//   slave  : surrounding pipeline / instruction memory
// Optional FETCH_INTR_EN adds intr, int_ack, int_ret_pc.
interface fetch_stage_if;
  import cpu_defs::*;
  logic          stall_F;
  logic          redirect_E;
  logic [DW-1:0] target_E;
  logic          halt_D;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] pc_reg_out;
  logic [DW-1:0] pc_plus_1_out;
  logic          fetch_valid;
  logic          halted;
`ifdef FETCH_INTR_EN
  logic          intr;
  logic          int_ack;
  logic [DW-1:0] int_ret_pc;
`endif

  modport master (
    input  stall_F, redirect_E, target_E, halt_D, imem_data,
`ifdef FETCH_INTR_EN
    input  intr,
    output int_ack, int_ret_pc,
`endif
    output imem_addr, instr_out, pc_reg_out, pc_plus_1_out, fetch_valid, halted
  );

  modport slave (
    output stall_F, redirect_E, target_E, halt_D, imem_data,
`ifdef FETCH_INTR_EN
    output intr,
    input  int_ack, int_ret_pc,
`endif
    input  imem_addr, instr_out, pc_reg_out, pc_plus_1_out, fetch_valid, halted
  );
endinterface

// File: rtl/fetch_stage_pc_register.sv
// pc_register: W-bit program counter with async active-low clear.
//   clk, reset : clock / async active-low clear
//   load       : 1 = take d, 0 = hold
//   d, q       : next-PC in, current PC out
module pc_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)    q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory address and feeds
// instruction / PC / PC+1 to the IF/ID register. Handles reset-vector boot,
// Execute redirects, hazard freezes (stall_F=0) and HLT.
//   clk, reset : clock, async active-low reset
//   bus        : fetch_stage_if.master (controls, imem, IF/ID outputs)
// Optional macro FETCH_INTR_EN: level-rise interrupt, vectored through
// INT_VEC_ADDR, with int_ack pulse and saved return PC.
module fetch_stage #(
  parameter int                    DW             = cpu_defs::DW,
  parameter logic [cpu_defs::DW-1:0] RESET_VEC_ADDR = cpu_defs::RESET_VEC_ADDR,
  parameter logic [cpu_defs::DW-1:0] NOP_INSTR      = cpu_defs::NOP_INSTR
`ifdef FETCH_INTR_EN
  , parameter logic [cpu_defs::DW-1:0] INT_VEC_ADDR = cpu_defs::INT_VEC_ADDR
`endif
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  import cpu_defs::*;

  fetch_state_e    state_q, state_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic            pc_ld;
  logic            take_int;

  pc_register #(.W(DW)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_ld),
    .d     (pc_d),
    .q     (pc_q)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_BOOT;
    else        state_q <= state_d;

`ifdef FETCH_INTR_EN
  logic          intr_q, pend_q, int_ack_q;
  logic [DW-1:0] ret_q;
  logic          pend_eff;
  logic          intr_rise;

  // A rise seen this cycle counts immediately so the return PC is the
  // instruction on the bus when intr rose.
  assign intr_rise = bus.intr & ~intr_q;
  assign pend_eff  = pend_q | (intr_rise & ((state_q == S_RUN) | (state_q == S_HALT)));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      intr_q    <= 1'b0;
      pend_q    <= 1'b0;
      int_ack_q <= 1'b0;
      ret_q     <= '0;
    end else begin
      intr_q    <= bus.intr;
      pend_q    <= pend_eff & ~take_int;
      int_ack_q <= take_int;
      if (take_int) ret_q <= pc_q;
    end

  assign bus.int_ack    = int_ack_q;
  assign bus.int_ret_pc = ret_q;
`else
  assign take_int = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_ld           = 1'b0;
    bus.imem_addr   = pc_q;
    bus.instr_out   = NOP_INSTR;
    bus.fetch_valid = 1'b0;
    bus.halted      = 1'b0;
`ifdef FETCH_INTR_EN
    take_int        = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        bus.imem_addr = RESET_VEC_ADDR;
        pc_d          = bus.imem_data;
        pc_ld         = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN: begin
        bus.instr_out   = bus.imem_data;
        bus.fetch_valid = 1'b1;
        // Redirect flushes the younger HLT and beats a freeze.
        if (bus.redirect_E) begin
          pc_d  = bus.target_E;
          pc_ld = 1'b1;
        end else if (bus.halt_D) begin
          state_d = S_HALT;
`ifdef FETCH_INTR_EN
        end else if (pend_eff && bus.stall_F) begin
          take_int = 1'b1;
          state_d  = S_INTV;
`endif
        end else if (bus.stall_F) begin
          pc_d  = pc_q + DW'(1);
          pc_ld = 1'b1;
        end
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.redirect_E) begin
          pc_d    = bus.target_E;
          pc_ld   = 1'b1;
          state_d = S_RUN;
`ifdef FETCH_INTR_EN
        end else if (pend_eff) begin
          take_int = 1'b1;
          state_d  = S_INTV;
`endif
        end
      end
`ifdef FETCH_INTR_EN
      S_INTV: begin
        bus.imem_addr = INT_VEC_ADDR;
        pc_d          = bus.imem_data;
        pc_ld         = 1'b1;
        state_d       = S_RUN;
      end
`endif
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.pc_reg_out    = pc_q;
  assign bus.pc_plus_1_out = pc_q + DW'(1);
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr];

`ifdef FETCH_INTR_EN
  initial bus.intr = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr, instr, pc, pc1;
    logic       valid, halted;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0=boot, 1=running, 2=halted; PC as plain byte.
  int         mst = 0;
  logic [7:0] mpc = 8'h00;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, predict this cycle's outputs, then advance
  // the model across the rising edge.
  task automatic step(input logic rst, input logic s, input logic r,
                      input logic [7:0] t, input logic h);
    exp_t e;
    reset          = rst;
    bus.stall_F    = s;
    bus.redirect_E = r;
    bus.target_E   = t;
    bus.halt_D     = h;
    if (!rst) begin mst = 0; mpc = 8'h00; end
    e.pc     = mpc;
    e.pc1    = mpc + 8'd1;
    e.valid  = (mst == 1);
    e.halted = (mst == 2);
    e.addr   = (mst == 0) ? RESET_VEC_ADDR : mpc;
    e.instr  = (mst == 1) ? mem[mpc] : NOP_INSTR;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (mst == 0) begin
        mpc = mem[RESET_VEC_ADDR]; mst = 1;
      end else if (mst == 1) begin
        if (r)      mpc = t;
        else if (h) mst = 2;
        else if (s) mpc = mpc + 8'd1;
      end else begin
        if (r) begin mpc = t; mst = 1; end
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("imem_addr",     bus.imem_addr,     e.addr);
      chk("instr_out",     bus.instr_out,     e.instr);
      chk("pc_reg_out",    bus.pc_reg_out,    e.pc);
      chk("pc_plus_1_out", bus.pc_plus_1_out, e.pc1);
      chk("fetch_valid",   {7'd0, bus.fetch_valid}, {7'd0, e.valid});
      chk("halted",        {7'd0, bus.halted},      {7'd0, e.halted});
    end
  end

  initial begin
    logic       rs, s, r, h;
    logic [7:0] t;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10;
    bus.stall_F = 1'b1; bus.redirect_E = 1'b0; bus.target_E = 8'h00; bus.halt_D = 1'b0;
    @(posedge clk); #1;

    // reset, boot cycle, first fetch at 10
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    // sequential wrap FE, FF, 00
    step(1, 1, 1, 8'hFE, 0);
    repeat (3) step(1, 1, 0, 8'h00, 0);
    // freeze at 20 then release
    step(1, 1, 1, 8'h20, 0);
    repeat (2) step(1, 0, 0, 8'h00, 0);
    repeat (2) step(1, 1, 0, 8'h00, 0);
    // redirect beats freeze and halt
    step(1, 0, 1, 8'h40, 1);
    step(1, 1, 0, 8'h00, 0);
    // halt at 33, held with noisy stall/halt, redirect to 50
    step(1, 1, 1, 8'h33, 0);
    step(1, 1, 0, 8'h00, 1);
    repeat (10) step(1, 1'($urandom_range(0, 1)), 0, 8'h00, 1'($urandom_range(0, 1)));
    step(1, 1, 1, 8'h50, 0);
    repeat (2) step(1, 1, 0, 8'h00, 0);
    // halt again, then async reset mid-halt and reboot
    step(1, 1, 0, 8'h00, 1);
    repeat (2) step(1, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);

    // randomized traffic
    repeat (500) begin
      rs = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 9) < 8);
      r  = ($urandom_range(0, 9) == 0);
      h  = ($urandom_range(0, 24) == 0);
      t  = 8'($urandom);
      step(rs, s, r, t, h);
    end

    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
